// File: rtl/npc_bus_pkg.sv
// Shared bus definitions for the NPC memory arbiter.
// Holds the arbiter state encoding and master IDs.
package npc_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ERR  = 2'd3
  } arb_state_e;

  localparam logic MID_IFU = 1'b0;
  localparam logic MID_LSU = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker (combinational).
// Ports: i_valid0 (IFU), i_valid1 (LSU), i_last -> o_grant_valid, o_grant_id.
module rr_pick2
  import npc_bus_pkg::*;
(
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last,
  output logic o_grant_valid,
  output logic o_grant_id
);

  assign o_grant_valid = i_valid0 | i_valid1;

  always_comb begin
    o_grant_id = MID_IFU;
    case ({i_valid1, i_valid0})
      // contention: the master not served last time wins
      2'b11:   o_grant_id = (i_last == MID_IFU) ? MID_LSU : MID_IFU;
      2'b10:   o_grant_id = MID_LSU;
      default: o_grant_id = MID_IFU;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU; one transaction in flight.
// Ports: ifu_*/lsu_* master side, mem_* memory side, resp_rdata, err.
module mem_arbiter
  import npc_bus_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_resp_valid,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                err
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e r_state;
  arb_state_e w_next;

  logic             r_last;
  logic             r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ifu_rv;
  logic             r_lsu_rv;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W/8-1:0] r_wmask;

  logic w_gv;
  logic w_gid;
  logic w_grant;
  logic w_busy;
  logic w_resp;
  logic w_exit;
  logic w_tmo;

  rr_pick2 u_pick (
    .i_valid0      (ifu_req_valid),
    .i_valid1      (lsu_req_valid),
    .i_last        (r_last),
    .o_grant_valid (w_gv),
    .o_grant_id    (w_gid)
  );

  // readys are gated by reset so they drop the moment rst goes low
  assign w_grant = rst & (r_state == ST_IDLE) & w_gv;
  assign w_busy  = (r_state == ST_REQ) | (r_state == ST_WAIT);
  assign w_resp  = (r_state == ST_WAIT) & mem_resp_valid;
  assign w_exit  = ((r_state == ST_REQ) & mem_req_ready) | w_resp;
  // an exit in the last allowed cycle beats the timeout
  assign w_tmo   = w_busy & ~w_exit & (r_cnt >= CNT_LAST);

  assign ifu_req_ready  = w_grant & (w_gid == MID_IFU);
  assign lsu_req_ready  = w_grant & (w_gid == MID_LSU);
  assign ifu_resp_valid = r_ifu_rv;
  assign lsu_resp_valid = r_lsu_rv;
  assign resp_rdata     = r_rdata;
  assign mem_req_valid  = (r_state == ST_REQ);
  assign mem_addr       = r_addr;
  assign mem_wen        = r_wen;
  assign mem_wdata      = r_wdata;
  assign mem_wmask      = r_wmask;
  assign err            = (r_state == ST_ERR);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_grant) w_next = ST_REQ;
      end
      ST_REQ: begin
        if (mem_req_ready) w_next = ST_WAIT;
        else if (w_tmo)    w_next = ST_ERR;
      end
      ST_WAIT: begin
        if (mem_resp_valid) w_next = ST_IDLE;
        else if (w_tmo)     w_next = ST_ERR;
      end
      ST_ERR: begin
        w_next = ST_ERR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last  <= MID_LSU;
      r_owner <= MID_IFU;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wen   <= 1'b0;
      r_wdata <= '0;
      r_wmask <= '0;
    end else if (w_grant) begin
      r_last  <= w_gid;
      r_owner <= w_gid;
      r_cnt   <= '0;
      if (w_gid == MID_LSU) begin
        r_addr  <= lsu_addr;
        r_wen   <= lsu_wen;
        r_wdata <= lsu_wdata;
        r_wmask <= lsu_wmask;
      end else begin
        r_addr  <= ifu_addr;
        r_wen   <= 1'b0;
        r_wdata <= '0;
        r_wmask <= '0;
      end
    end else if (w_busy) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ifu_rv <= 1'b0;
      r_lsu_rv <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_ifu_rv <= w_resp & (r_owner == MID_IFU);
      r_lsu_rv <= w_resp & (r_owner == MID_LSU);
      if (w_resp) r_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT=8).
// Drives at posedge+1, checks combinational/registered outputs mid-cycle.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_resp_valid;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_resp_valid;
  logic [31:0] resp_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;

  mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_addr       (lsu_addr),
    .lsu_wen        (lsu_wen),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .resp_rdata     (resp_rdata),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_addr       (mem_addr),
    .mem_wen        (mem_wen),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_rdata      (mem_rdata),
    .err            (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  exp_rdy;
  logic [69:0] exp_req;

  initial begin
    rst = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_addr = '0;
    lsu_req_valid = 1'b1;
    lsu_addr = '0;
    lsu_wen = 1'b0;
    lsu_wdata = '0;
    lsu_wmask = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h1111_2222;

    // reset state
    #2;
    check("rst_ready", 128'({ifu_req_ready, lsu_req_ready}), 128'(2'b00));
    check("rst_valid", 128'({mem_req_valid, ifu_resp_valid,
                             lsu_resp_valid, err}), 128'(4'b0000));
    check("rst_data", 128'({mem_addr, mem_wdata, mem_wmask,
                            mem_wen, resp_rdata}), 128'(0));

    // IFU-only read
    @(posedge clk);
    #1;
    lsu_req_valid = 1'b0;
    mem_resp_valid = 1'b0;
    ifu_addr = 32'h8000_0000;
    mem_req_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("ifu_grant", 128'({ifu_req_ready, lsu_req_ready}), 128'(2'b10));
    cyc;
    ifu_req_valid = 1'b0;
    check("ifu_req", 128'({mem_req_valid, mem_wen, mem_addr}),
          128'({1'b1, 1'b0, 32'h8000_0000}));
    cyc;
    check("ifu_hs_drop", 128'(mem_req_valid), 128'(1'b0));
    mem_resp_valid = 1'b1;
    mem_rdata = 32'h0000_0413;
    cyc;
    mem_resp_valid = 1'b0;
    check("ifu_resp", 128'({ifu_resp_valid, lsu_resp_valid, resp_rdata}),
          128'({2'b10, 32'h0000_0413}));
    cyc;
    check("ifu_pulse", 128'({ifu_resp_valid, lsu_resp_valid}), 128'(2'b00));

    // backpressure on an LSU write
    lsu_req_valid = 1'b1;
    lsu_addr = 32'h8000_2000;
    lsu_wen = 1'b1;
    lsu_wdata = 32'h1234_5678;
    lsu_wmask = 4'b0101;
    mem_req_ready = 1'b0;
    #1;
    check("bp_grant", 128'({ifu_req_ready, lsu_req_ready}), 128'(2'b01));
    cyc;
    lsu_req_valid = 1'b0;
    lsu_addr = 32'h0BAD_0000;
    lsu_wdata = '0;
    ifu_req_valid = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_hold", 128'({mem_req_valid, mem_wen, mem_wmask,
                             mem_addr, mem_wdata}),
            128'({1'b1, 1'b1, 4'b0101, 32'h8000_2000, 32'h1234_5678}));
      check("bp_ready", 128'({ifu_req_ready, lsu_req_ready}), 128'(2'b00));
      cyc;
    end
    mem_req_ready = 1'b1;
    ifu_req_valid = 1'b0;
    check("bp_last", 128'(mem_req_valid), 128'(1'b1));
    cyc;
    mem_req_ready = 1'b0;
    check("bp_wait", 128'(mem_req_valid), 128'(1'b0));
    mem_resp_valid = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    cyc;
    mem_resp_valid = 1'b0;
    check("bp_resp", 128'({err, ifu_resp_valid, lsu_resp_valid,
                           resp_rdata}),
          128'({3'b001, 32'hCAFE_F00D}));

    // response in the last allowed cycle
    lsu_wen = 1'b0;
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0080;
    #1;
    check("bnd_grant", 128'({ifu_req_ready, lsu_req_ready}), 128'(2'b10));
    cyc;
    ifu_req_valid = 1'b0;
    cyc;
    cyc;
    cyc;
    mem_req_ready = 1'b1;
    cyc;
    mem_req_ready = 1'b0;
    cyc;
    cyc;
    cyc;
    mem_resp_valid = 1'b1;
    mem_rdata = 32'hB0B0_0007;
    check("bnd_last", 128'({err, mem_req_valid}), 128'(2'b00));
    cyc;
    mem_resp_valid = 1'b0;
    check("bnd_resp", 128'({err, ifu_resp_valid, lsu_resp_valid,
                            resp_rdata}),
          128'({3'b010, 32'hB0B0_0007}));
    cyc;
    check("bnd_after", 128'({err, ifu_resp_valid, lsu_resp_valid}),
          128'(3'b000));

    // asynchronous reset while in WAIT
    ifu_req_valid = 1'b1;
    ifu_addr = 32'h8000_0100;
    mem_req_ready = 1'b1;
    cyc;
    lsu_req_valid = 1'b1;
    lsu_addr = 32'h8000_1000;
    lsu_wen = 1'b1;
    lsu_wdata = 32'hDEAD_BEEF;
    lsu_wmask = 4'b1111;
    cyc;
    check("rw_pre", 128'({mem_req_valid, mem_addr}),
          128'({1'b0, 32'h8000_0100}));
    #2 rst = 1'b0;
    #1;
    check("rw_ready", 128'({ifu_req_ready, lsu_req_ready}), 128'(2'b00));
    check("rw_data", 128'({mem_addr, mem_wdata, mem_wmask,
                           mem_wen, resp_rdata}), 128'(0));
    mem_resp_valid = 1'b1;
    cyc;
    cyc;
    check("rw_noresp", 128'({mem_req_valid, ifu_resp_valid,
                             lsu_resp_valid, err}), 128'(4'b0000));
    mem_resp_valid = 1'b0;
    #2 rst = 1'b1;
    #1;

    // contention: alternating grants, IFU first after reset
    for (int i = 0; i < 4; i++) begin
      exp_rdy = (i % 2 == 0) ? 2'b10 : 2'b01;
      exp_req = (i % 2 == 0)
              ? {1'b1, 1'b0, 32'h8000_0100, 32'h0, 4'h0}
              : {1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF};
      check("ct_grant", 128'({ifu_req_ready, lsu_req_ready}),
            128'(exp_rdy));
      cyc;
      check("ct_req", 128'({mem_req_valid, mem_wen, mem_addr,
                            mem_wdata, mem_wmask}), 128'(exp_req));
      cyc;
      mem_resp_valid = 1'b1;
      mem_rdata = 32'h5000_0000 + i;
      cyc;
      mem_resp_valid = 1'b0;
      #1;
      check("ct_resp", 128'({ifu_resp_valid, lsu_resp_valid, resp_rdata}),
            128'({exp_rdy, 32'h5000_0000 + i}));
    end
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    cyc;

    // timeout: memory accepts but never responds
    lsu_req_valid = 1'b1;
    lsu_wen = 1'b0;
    lsu_addr = 32'h8000_3000;
    mem_req_ready = 1'b1;
    #1;
    check("to_grant", 128'({ifu_req_ready, lsu_req_ready}), 128'(2'b01));
    cyc;
    lsu_req_valid = 1'b0;
    check("to_req", 128'(mem_req_valid), 128'(1'b1));
    for (int k = 0; k < 8; k++) begin
      check("to_run", 128'({err, ifu_resp_valid, lsu_resp_valid}),
            128'(3'b000));
      cyc;
    end
    check("to_err", 128'({err, mem_req_valid, ifu_resp_valid,
                          lsu_resp_valid}), 128'(4'b1000));
    mem_resp_valid = 1'b1;
    ifu_req_valid = 1'b1;
    lsu_req_valid = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check("to_ready", 128'({ifu_req_ready, lsu_req_ready}), 128'(2'b00));
      check("to_stuck", 128'({err, mem_req_valid, ifu_resp_valid,
                              lsu_resp_valid}), 128'(4'b1000));
      cyc;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single data-memory port between the IFU (instruction fetch) and the LSU (load/store) once fetch and memory access leave the single-cycle path.
- Accepts valid/ready requests from both masters and allows at most one outstanding memory transaction.
- Routes each response back to the master that issued it.
- Detects a memory hang with a timeout counter and halts arbitration with a sticky error.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; wmask width is DATA_W/8.
- TIMEOUT, 1024, maximum cycles from mem_req_valid assertion to mem_resp_valid before error; must be ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset; asserted at 0.
- ifu_req_valid  in  1  IFU read request.
- ifu_req_ready  out  1  IFU request accepted this cycle.
- ifu_addr  in  ADDR_W  IFU fetch address.
- ifu_resp_valid  out  1  IFU response pulse.
- lsu_req_valid  in  1  LSU request.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_addr  in  ADDR_W  LSU address.
- lsu_wen  in  1  1 = write.
- lsu_wdata  in  DATA_W  LSU write data.
- lsu_wmask  in  DATA_W/8  byte strobes.
- lsu_resp_valid  out  1  LSU response pulse.
- resp_rdata  out  DATA_W  response data, shared; qualified by either resp_valid.
- mem_req_valid  out  1  request to memory.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_W
- mem_wen  out  1
- mem_wdata  out  DATA_W
- mem_wmask  out  DATA_W/8
- mem_resp_valid  in  1  memory response (reads and writes).
- mem_rdata  in  DATA_W
- err  out  1  sticky timeout flag.

Behaviour:
- **Reset (rst=0, asynchronous):**
  - state=IDLE, last_grant=LSU, owner=IFU, timeout counter=0.
  - All *_valid and *_ready outputs 0, err=0, resp_rdata=0.
  - mem_addr/mem_wdata/mem_wmask=0, mem_wen=0.
  - Reset mid-transaction abandons it; no response is issued.
- **States:** IDLE, REQ, WAIT, ERR.
- **IDLE:**
  - Winner is combinational.
    - Only one master valid: that master wins.
    - Both valid: the master other than last_grant wins (round-robin).
  - The winner's req_ready is 1 in the same cycle; the loser's is 0. Both readys are 0 in every other state.
  - On a grant:
    - Register addr, wen, wdata and wmask into the mem_* registers. IFU grants force wen=0, wdata=0, wmask=0.
    - Set owner and last_grant to the winner, clear the counter, go to REQ.
- **REQ:**
  - mem_req_valid=1; mem_* fields held stable.
  - On mem_req_ready=1, go to WAIT.
  - mem_req_valid deasserts the cycle after the handshake.
- **WAIT:**
  - On mem_resp_valid=1:
    - Register mem_rdata into resp_rdata.
    - Pulse owner's resp_valid for exactly one cycle, the cycle after mem_resp_valid.
    - Go to IDLE.
  - A new grant may occur in the same cycle that resp_valid is high.
- **Latency:** with zero-wait memory (mem_req_ready=1, mem_resp_valid the cycle after the handshake):
  - grant at cycle 0, mem handshake at cycle 1, mem_resp at cycle 2, resp_valid at cycle 3.
  - Back-to-back issue rate is one transaction per 3 cycles.
- **Timeout:**
  - The counter increments every cycle in REQ and WAIT.
  - If it reaches TIMEOUT-1 without the state exiting:
    - Go to ERR, set err=1, drop mem_req_valid.
    - No resp_valid is issued.
  - If the exit event coincides with the counter reaching TIMEOUT-1, the exit wins and there is no error.
- **ERR:**
  - Terminal until reset; no grants.
  - mem_resp_valid is ignored.
  - err stays 1.
- **Protocol errors:** mem_resp_valid outside WAIT is ignored. Master request fields are sampled only at the grant.
- **Fairness:** with both masters continuously valid, grants strictly alternate, starting with IFU after reset.

Decomposition:
- Shared package npc_bus_pkg holds:
  - state encoding (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, ERR=2'd3);
  - master IDs (MID_IFU=1'b0, MID_LSU=1'b1).
- One natural sub-module, rr_pick2: combinational two-way round-robin picker.
  - Inputs: two valids, last_grant.
  - Outputs: grant_valid, grant_id.
- FSM, counter and datapath registers stay in mem_arbiter.

Test Plan:
- **IFU-only read:**
  - Stimulus: ifu_req_valid=1, ifu_addr=0x8000_0000; memory ready and rdata=0x0000_0413 one cycle after the handshake.
  - Expected: ifu_req_ready at cycle 0; mem_addr=0x8000_0000 with mem_wen=0; ifu_resp_valid for one cycle at cycle 3 with resp_rdata=0x0000_0413; lsu_resp_valid stays 0.
- **Contention:**
  - Stimulus: both masters continuously valid from reset; LSU write to 0x8000_1000, wdata=0xDEAD_BEEF, wmask=4'b1111.
  - Expected: grants in order IFU, LSU, IFU, LSU; the LSU transaction drives mem_wen=1 and mem_wdata=0xDEAD_BEEF; each response goes only to its owner.
- **Backpressure:**
  - Stimulus: mem_req_ready held 0 for 5 cycles after grant.
  - Expected: mem_req_valid and all mem_* fields stable for all 5 cycles; both readys 0; completion follows normally.
- **Timeout:**
  - Stimulus: TIMEOUT=8; memory never asserts mem_resp_valid.
  - Expected: err=1 exactly 8 cycles after REQ entry; no resp_valid; a later mem_resp_valid and new requests are ignored.
- **Boundary:**
  - Stimulus: TIMEOUT=8; mem_resp_valid arrives in the last allowed cycle.
  - Expected: normal response, err stays 0.
- **Reset mid-WAIT:**
  - Stimulus: assert rst=0 asynchronously while in WAIT.
  - Expected: all outputs clear immediately without waiting for a clock edge; after release, the first grant with both masters valid goes to IFU.
